// File: rtl/inst_fetch_queue.sv
// Dual-lane circular instruction buffer between fetch and decode.
// Accepts up to two entries per cycle and presents the two oldest entries in program order.
module inst_fetch_queue #(
  parameter int DEPTH = 16,
  parameter int EXC_W = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  logic [1:0][31:0]      in_pc,
  input  logic [1:0][31:0]      in_inst,
  input  logic [1:0][EXC_W-1:0] in_exception,
  output logic                  in_ready,
  output logic [1:0]            out_valid,
  output logic [1:0][31:0]      out_pc,
  output logic [1:0][31:0]      out_inst,
  output logic [1:0][EXC_W-1:0] out_exception,
  input  logic                  dec_ready,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [EXC_W-1:0] exc_mem  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W:0]   cnt;
  logic             push;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Readiness depends on registered occupancy only, so fetch never sees a pop-dependent path.
  assign in_ready = (cnt <= READY_MAX);
  assign push     = in_ready && in_valid[0];

  assign out_valid[0] = (cnt != '0);
  assign out_valid[1] = (cnt > CNT_ONE);
  assign count        = cnt;

  always_comb begin
    push_n = 2'd0;
    if (push) begin
      push_n = in_valid[1] ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    pop_n = 2'd0;
    if (dec_ready) begin
      if (out_valid[1]) begin
        pop_n = 2'd2;
      end else if (out_valid[0]) begin
        pop_n = 2'd1;
      end
    end
  end

  assign out_pc[0]        = pc_mem[head];
  assign out_pc[1]        = pc_mem[head_p1];
  assign out_inst[0]      = inst_mem[head];
  assign out_inst[1]      = inst_mem[head_p1];
  assign out_exception[0] = exc_mem[head];
  assign out_exception[1] = exc_mem[head_p1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(pop_n);
      tail <= tail + PTR_W'(push_n);
      cnt  <= cnt + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[tail]   <= in_pc[0];
      inst_mem[tail] <= in_inst[0];
      exc_mem[tail]  <= in_exception[0];
      if (in_valid[1]) begin
        pc_mem[tail_p1]   <= in_pc[1];
        inst_mem[tail_p1] <= in_inst[1];
        exc_mem[tail_p1]  <= in_exception[1];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed checks of inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 16;
  localparam int EXC_W = 8;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [EXC_W-1:0] exc;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  flush;
  logic [1:0]            in_valid;
  logic [1:0][31:0]      in_pc;
  logic [1:0][31:0]      in_inst;
  logic [1:0][EXC_W-1:0] in_exception;
  logic                  in_ready;
  logic [1:0]            out_valid;
  logic [1:0][31:0]      out_pc;
  logic [1:0][31:0]      out_inst;
  logic [1:0][EXC_W-1:0] out_exception;
  logic                  dec_ready;
  logic [PTR_W:0]        count;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t mq[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_inst       (in_inst),
    .in_exception  (in_exception),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_exception (out_exception),
    .dec_ready     (dec_ready),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    int sz;
    ent_t e;
    sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("count_le_depth", 64'(count <= (PTR_W+1)'(DEPTH)), 64'(1));
    chk("in_ready", 64'(in_ready), 64'(sz <= DEPTH - 2));
    chk("out_valid", 64'(out_valid), (sz >= 2) ? 64'd3 : (sz == 1) ? 64'd1 : 64'd0);
    chk("out_valid_not_10", 64'(out_valid == 2'b10), 64'(0));
    if (sz >= 1) begin
      e = mq[0];
      chk("lane0_pc", 64'(out_pc[0]), 64'(e.pc));
      chk("lane0_inst", 64'(out_inst[0]), 64'(e.inst));
      chk("lane0_exc", 64'(out_exception[0]), 64'(e.exc));
    end
    if (sz >= 2) begin
      e = mq[1];
      chk("lane1_pc", 64'(out_pc[1]), 64'(e.pc));
      chk("lane1_inst", 64'(out_inst[1]), 64'(e.inst));
      chk("lane1_exc", 64'(out_exception[1]), 64'(e.exc));
    end
  endtask

  // Applies the architectural rules to the model using the inputs held across the edge.
  task automatic model_step();
    int   sz;
    int   npop;
    bit   rdy;
    ent_t e;
    sz  = mq.size();
    rdy = (sz <= DEPTH - 2);
    if (flush) begin
      mq.delete();
      return;
    end
    npop = dec_ready ? ((sz >= 2) ? 2 : sz) : 0;
    for (int i = 0; i < npop; i++) void'(mq.pop_front());
    if (rdy && in_valid[0]) begin
      e = '{pc: in_pc[0], inst: in_inst[0], exc: in_exception[0]};
      mq.push_back(e);
      if (in_valid[1]) begin
        e = '{pc: in_pc[1], inst: in_inst[1], exc: in_exception[1]};
        mq.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                     input logic dr, input logic fl);
    in_valid        = v;
    in_pc[0]        = p0;
    in_pc[1]        = p1;
    in_inst[0]      = $urandom;
    in_inst[1]      = $urandom;
    in_exception[0] = EXC_W'($urandom);
    in_exception[1] = EXC_W'($urandom);
    dec_ready       = dr;
    flush           = fl;
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic dr);
    cyc(2'b00, 32'h0, 32'h0, dr, 1'b0);
  endtask

  task automatic fill_dual(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) cyc(2'b11, base + 32'(8 * i), base + 32'(8 * i + 4), 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    flush = 1'b0; in_valid = 2'b00; dec_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_exception = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    #3 resetn = 1'b1;
    @(posedge clk); #1;

    // Dual push shows up on both lanes the following cycle
    cyc(2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 1'b0, 1'b0);
    chk("t1_out_valid", 64'(out_valid), 64'(2'b11));
    chk("t1_pc0", 64'(out_pc[0]), 64'(32'hBFC0_0000));
    chk("t1_pc1", 64'(out_pc[1]), 64'(32'hBFC0_0004));
    chk("t1_count", 64'(count), 64'(2));

    // Fill to full; a push offered while not ready is dropped
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    fill_dual(7, 32'h0000_1000);
    chk("t2_count14", 64'(count), 64'(14));
    chk("t2_ready14", 64'(in_ready), 64'(1));
    cyc(2'b11, 32'h0000_2000, 32'h0000_2004, 1'b0, 1'b0);
    chk("t2_count16", 64'(count), 64'(16));
    chk("t2_ready16", 64'(in_ready), 64'(0));
    cyc(2'b11, 32'h0000_3000, 32'h0000_3004, 1'b0, 1'b0);
    chk("t2_count_hold", 64'(count), 64'(16));
    chk("t2_pc0_hold", 64'(out_pc[0]), 64'(32'h0000_1000));

    // Single push then single pop
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(2'b01, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("t3_valid01", 64'(out_valid), 64'(2'b01));
    chk("t3_count1", 64'(count), 64'(1));
    idle(1'b1);
    chk("t3_valid00", 64'(out_valid), 64'(2'b00));
    chk("t3_count0", 64'(count), 64'(0));

    // Lane-1-only offer is not a push
    cyc(2'b10, 32'h0000_4000, 32'h0000_4004, 1'b0, 1'b0);
    chk("t3_v10_nopush", 64'(count), 64'(0));

    // Walk pointers to slot 15, then wrap a dual push across the end
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      cyc(2'b01, 32'h0000_5000 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
      idle(1'b1);
    end
    cyc(2'b11, 32'h0000_0100, 32'h0000_0104, 1'b0, 1'b0);
    chk("t4_pc0", 64'(out_pc[0]), 64'(32'h0000_0100));
    chk("t4_pc1", 64'(out_pc[1]), 64'(32'h0000_0104));
    idle(1'b1);
    chk("t4_empty", 64'(count), 64'(0));

    // Dual push and dual pop at count 14
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    fill_dual(7, 32'h0000_6000);
    cyc(2'b11, 32'h0000_7000, 32'h0000_7004, 1'b1, 1'b0);
    chk("t5_count14", 64'(count), 64'(14));
    chk("t5_pc0", 64'(out_pc[0]), 64'(32'h0000_6008));

    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  v;
      logic [31:0] p;
      v = 2'($urandom_range(0, 3));
      p = $urandom & 32'hFFFF_FFFC;
      cyc(v, p, p + 32'd4, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 63) == 0));
    end

    // Flush with a push in flight
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    fill_dual(4, 32'h0000_8000);
    cyc(2'b01, 32'h0000_8100, 32'h0, 1'b0, 1'b0);
    chk("t6_count9", 64'(count), 64'(9));
    cyc(2'b11, 32'h0000_9000, 32'h0000_9004, 1'b1, 1'b1);
    chk("t6_count0", 64'(count), 64'(0));
    chk("t6_valid00", 64'(out_valid), 64'(0));
    chk("t6_ready", 64'(in_ready), 64'(1));
    cyc(2'b01, 32'hBFC0_0380, 32'h0, 1'b0, 1'b0);
    chk("t6_fresh_pc", 64'(out_pc[0]), 64'(32'hBFC0_0380));
    chk("t6_fresh_valid", 64'(out_valid), 64'(2'b01));

    // Asynchronous reset between clock edges
    fill_dual(3, 32'h0000_A000);
    in_valid = 2'b00; flush = 1'b0; dec_ready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    mq.delete();
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    cyc(2'b11, 32'h0000_B000, 32'h0000_B004, 1'b0, 1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-lane circular instruction buffer between the fetch stage and the decode stage.
- Accepts up to 2 fetched instructions per cycle, each carrying pc, instruction word and fetch-side exception.
- Presents the 2 oldest entries, in program order, to the two decode lanes (lane 0 = first inst, lane 1 = is_inst2 lane).
- Decouples fetch stalls from decode/dispatch stalls and is cleared on pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  pipeline flush (exception/eret/branch mispredict); clears queue
- in_valid  input  2  per-lane fetch valid; bit1 only legal with bit0
- in_pc  input  2x32  virt_t pc per lane
- in_inst  input  2x32  uint32_t instruction word per lane
- in_exception  input  2x$bits(exception_t)  fetch exception per lane
- in_ready  output  1  queue can accept 2 entries this cycle
- out_valid  output  2  decode lane valid; bit1 implies bit0
- out_pc  output  2x32  pc to decode lane 0/1
- out_inst  output  2x32  instruction to decode lane 0/1
- out_exception  output  2x$bits(exception_t)  exception to decode lane 0/1
- dec_ready  input  1  decode consumes all asserted out_valid lanes this cycle
- count  output  PTR_W+1  current occupancy (debug/perf)

Behaviour:
- Reset (async, resetn=0): head=0, tail=0, count=0; out_valid=0, in_ready=1. Storage contents are don't-care.
- Storage is DEPTH registers indexed by head/tail. Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- in_ready = (count <= DEPTH-2). It is computed from the registered count only, with no dependence on the same-cycle pop.
- Push:
  - Fires when in_ready && in_valid[0].
  - Lane 0 is written at tail. If in_valid[1]=1, lane 1 is written at tail+1.
  - tail advances by popcount of the accepted lanes.
  - in_valid=2'b10 is treated as no push; lane 1 is dropped.
  - When in_ready=0, inputs are ignored. Fetch must hold its data.
- Output (combinational from registers):
  - out_valid[0] = count>=1.
  - out_valid[1] = count>=2.
  - Lane 0 data = entry[head]; lane 1 data = entry[head+1 mod DEPTH].
  - When out_valid is 0, the corresponding output data is don't-care.
- Pop: when dec_ready=1, head advances by popcount(out_valid), i.e. 0, 1 or 2. There is no partial pop of lane 0 only while lane 1 is valid.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest. There is no bypass.
- Simultaneous push and pop: count_next = count + pushed - popped. This is legal at any occupancy, including count=DEPTH-2 with a 2-push and a 2-pop.
- Wrap-around: a 2-entry push with tail=DEPTH-1 writes entry[DEPTH-1] and entry[0]. The same applies to head on pop.
- flush (synchronous, highest priority):
  - Next cycle: head=tail=0, count=0, out_valid=0.
  - A push or pop in the flush cycle is discarded.
  - in_ready is unchanged in the flush cycle and reads 1 in the following cycle.
- Reset mid-operation: asserting resetn=0 clears the queue immediately (async). Outputs go to reset values regardless of clk.
- Ordering invariant: lane 0 output is always older than lane 1 output. Program order is preserved across wrap.
- Assertions for the verification bench:
  - count <= DEPTH.
  - out_valid != 2'b10.
  - No push when in_ready=0.

Test Plan:
1. Reset, then push {pc=0xBFC00000, 0xBFC00004} in one cycle with dec_ready=0. Next cycle: out_valid=2'b11, out_pc = {0xBFC00000, 0xBFC00004}, count=2.
2. Fill with 7 dual pushes (count=14), then attempt an 8th push. Required: in_ready=0 after count reaches 15 or 16 is impossible; count must stay 14→16 with in_ready=0 at 16. A push offered while in_ready=0 is not stored and count stays unchanged.
3. Odd push: in_valid=2'b01 at pc 0x80000000, then dec_ready=1. The next cycle pops only lane 0: out_valid goes 01→00, count 1→0, head advances by 1.
4. Wrap: drive head=tail=15 via 15 single push/pop cycles, then dual push of pcs 0x100 and 0x104. The entries land in slots 15 and 0; out_pc = {0x100, 0x104} in order.
5. Simultaneous: at count=14, dual push and dual pop in the same cycle. Count stays 14, and data ordering is verified against a reference model over 1000 random push/pop cycles.
6. Flush with count=9 and push active: next cycle count=0, out_valid=00. The pushed entries are absent. A fresh push at 0xBFC00380 then appears at lane 0 one cycle later.
